// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Widths are fixed for a five-digit input and a 15-bit magnitude.
package bcd_pkg;

   localparam int unsigned N_DIGITS = 5;
   localparam int unsigned DIGIT_W  = 4;
   localparam int unsigned MAG_W    = 15;
   localparam int unsigned ACC_W    = 17;
   localparam int unsigned CNT_W    = 5;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      CONVERT = 2'd2,
      DONE    = 2'd3
   } state_t;

   // A nibble outside 0..9 is not a BCD digit.
   function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
      return digit > DIGIT_W'(9);
   endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// One BCD digit correction step for reverse double-dabble:
// after a right shift, any digit of 8 or more gets 3 subtracted.
module bcd_digit_corr
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit,
   output logic [DIGIT_W-1:0] corr_c
);

   assign corr_c = (digit >= DIGIT_W'(8)) ? digit - DIGIT_W'(3) : digit;

endmodule

// File: rtl/bcd_to_bin.sv
// Five-digit BCD to sign-magnitude binary converter (reverse double-dabble).
// Result is {sign, magnitude}; out-of-range or bad digits give zero plus a flag.
module bcd_to_bin #(
   parameter int unsigned N_DIGITS = bcd_pkg::N_DIGITS,
   parameter int unsigned MAG_W    = bcd_pkg::MAG_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       bcd_d_in_1,
   input  logic [3:0]       bcd_d_in_2,
   input  logic [3:0]       bcd_d_in_3,
   input  logic [3:0]       bcd_d_in_4,
   input  logic [3:0]       bcd_d_in_5,
   input  logic [3:0]       plus_minus,
   output logic [MAG_W:0]   bin_d_out,
   output logic             rdy,
   output logic             busy,
   output logic             err_digit,
   output logic             ovf
);

   import bcd_pkg::*;

   localparam int unsigned      BCD_W      = N_DIGITS * DIGIT_W;
   localparam int unsigned      SR_W       = BCD_W + ACC_W;
   localparam logic [ACC_W-1:0] MAG_MAX    = ACC_W'((2 ** MAG_W) - 1);
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(ACC_W - 1);

   state_t             state;
   state_t             state_nxt;
   logic [BCD_W-1:0]   bcd;
   logic [ACC_W-1:0]   acc;
   logic               sign;
   logic               bad;
   logic [CNT_W-1:0]   cnt;

   logic [BCD_W-1:0]   operand_c;
   logic [SR_W-1:0]    shifted_c;
   logic [BCD_W-1:0]   bcd_corr_c;
   logic               any_bad_c;
   logic               unused_pm_c;

   assign operand_c   = {bcd_d_in_5, bcd_d_in_4, bcd_d_in_3, bcd_d_in_2, bcd_d_in_1};
   assign unused_pm_c = ^plus_minus[3:1];

   // The BCD field and accumulator shift as one register; the accumulator
   // collects binary bits LSB-first from the top of the BCD field.
   assign shifted_c = {bcd, acc} >> 1;

   for (genvar g = 0; g < N_DIGITS; g++) begin : g_corr
      bcd_digit_corr u_corr (
         .digit  (shifted_c[ACC_W + g*DIGIT_W +: DIGIT_W]),
         .corr_c (bcd_corr_c[g*DIGIT_W +: DIGIT_W])
      );
   end

   always_comb begin
      any_bad_c = 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
         any_bad_c = any_bad_c | digit_invalid(bcd[i*DIGIT_W +: DIGIT_W]);
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (en) state_nxt = CHECK;
         CHECK:   state_nxt = any_bad_c ? DONE : CONVERT;
         CONVERT: if (cnt == LAST_SHIFT) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, shift datapath and registered results.
   always_ff @(posedge clk) begin
      if (rst) begin
         bcd       <= '0;
         acc       <= '0;
         sign      <= 1'b0;
         bad       <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         rdy       <= 1'b0;
         bin_d_out <= '0;
         err_digit <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         rdy <= 1'b0;
         unique case (state)
            IDLE: begin
               busy <= en;
               if (en) begin
                  bcd  <= operand_c;
                  acc  <= '0;
                  sign <= plus_minus[0];
                  bad  <= 1'b0;
               end
            end
            CHECK: begin
               bad <= any_bad_c;
               cnt <= '0;
            end
            CONVERT: begin
               bcd <= bcd_corr_c;
               acc <= shifted_c[ACC_W-1:0];
               cnt <= cnt + CNT_W'(1);
            end
            DONE: begin
               rdy <= 1'b1;
               if (bad) begin
                  bin_d_out <= '0;
                  err_digit <= 1'b1;
                  ovf       <= 1'b0;
               end else if (acc > MAG_MAX) begin
                  bin_d_out <= '0;
                  err_digit <= 1'b0;
                  ovf       <= 1'b1;
               end else begin
                  // Zero magnitude never carries a minus sign.
                  bin_d_out <= {sign & (acc[MAG_W-1:0] != '0), acc[MAG_W-1:0]};
                  err_digit <= 1'b0;
                  ovf       <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed and loop-back checks for bcd_to_bin: latency, flags, sign handling,
// operand isolation while busy, and mid-conversion reset.
module tb_bcd_to_bin;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [19:0] din;
   logic [3:0]  pm;
   logic [15:0] bin_d_out;
   logic        rdy;
   logic        busy;
   logic        err_digit;
   logic        ovf;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bcd_to_bin dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .bcd_d_in_1 (din[3:0]),
      .bcd_d_in_2 (din[7:4]),
      .bcd_d_in_3 (din[11:8]),
      .bcd_d_in_4 (din[15:12]),
      .bcd_d_in_5 (din[19:16]),
      .plus_minus (pm),
      .bin_d_out  (bin_d_out),
      .rdy        (rdy),
      .busy       (busy),
      .err_digit  (err_digit),
      .ovf        (ovf)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] to_bcd(input int value);
      logic [19:0] r;
      int          v;
      v = value;
      r = '0;
      for (int i = 0; i < 5; i++) begin
         r[i*4 +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   // Called from a point 1ns after an edge; the next edge is the accept edge.
   task automatic launch(input string tag, input logic [19:0] d, input logic [3:0] sgn);
      din = d;
      pm  = sgn;
      en  = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      check({tag, "_busy"}, 32'(busy), 32'd1);
   endtask

   task automatic wait_rdy(input string tag, input int exp_lat);
      int k;
      k = 0;
      while (!rdy && k < 40) begin
         @(posedge clk);
         #1;
         k++;
      end
      check({tag, "_lat"}, 32'(k), 32'(exp_lat));
   endtask

   task automatic convert(input string tag, input logic [19:0] d, input logic [3:0] sgn,
                          input logic [15:0] exp_out, input logic exp_err,
                          input logic exp_ovf, input int exp_lat);
      launch(tag, d, sgn);
      wait_rdy(tag, exp_lat);
      check({tag, "_out"}, 32'(bin_d_out), 32'(exp_out));
      check({tag, "_err"}, 32'(err_digit), 32'(exp_err));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
   endtask

   task automatic idle_check(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_rdy_low"}, 32'(rdy), 32'd0);
      check({tag, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int          k;
      int          val;
      logic        s;
      logic        seen;
      logic [15:0] exp_lb;

      rst = 1'b1;
      en  = 1'b1;
      din = 20'h12345;
      pm  = 4'h1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out", 32'(bin_d_out), 32'h0);
      check("rst_rdy", 32'(rdy), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err_digit), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      en  = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;

      convert("d12345", 20'h12345, 4'h0, 16'h3039, 1'b0, 1'b0, 19);
      idle_check("d12345");

      // Back-to-back: second request launched in the rdy cycle.
      convert("d32767", 20'h32767, 4'h0, 16'h7FFF, 1'b0, 1'b0, 19);
      convert("d32768", 20'h32768, 4'h0, 16'h0000, 1'b0, 1'b1, 19);
      idle_check("d32768");
      convert("d99999", 20'h99999, 4'h1, 16'h0000, 1'b0, 1'b1, 19);
      convert("neg1",   20'h00001, 4'h1, 16'h8001, 1'b0, 1'b0, 19);
      convert("negzero", 20'h00000, 4'h1, 16'h0000, 1'b0, 1'b0, 19);
      convert("d123_pmE", 20'h00123, 4'hE, 16'h007B, 1'b0, 1'b0, 19);
      convert("neg9999", 20'h09999, 4'hF, 16'hA70F, 1'b0, 1'b0, 19);

      convert("bad_d3", 20'h00A00, 4'h0, 16'h0000, 1'b1, 1'b0, 2);
      idle_check("bad_d3");
      check("bad_d3_hold_err", 32'(err_digit), 32'd1);
      convert("bad_d5", 20'hF1234, 4'h1, 16'h0000, 1'b1, 1'b0, 2);
      convert("clear_err", 20'h00010, 4'h1, 16'h800A, 1'b0, 1'b0, 19);
      idle_check("clear_err");

      // en held high with digits changing every cycle; only the accept-edge capture counts.
      din = 20'h00042;
      pm  = 4'h0;
      en  = 1'b1;
      @(posedge clk);
      #1;
      k = 0;
      while (!rdy && k < 40) begin
         din = din + 20'h01011;
         pm  = ~pm;
         @(posedge clk);
         #1;
         k++;
      end
      en = 1'b0;
      check("hold_lat", 32'(k), 32'd19);
      check("hold_out", 32'(bin_d_out), 32'h002A);
      idle_check("hold");

      // Reset asserted for the edge at E0+10 aborts the request.
      launch("abort", 20'h12345, 4'h1);
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_out", 32'(bin_d_out), 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_err", 32'(err_digit), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk);
         #1;
         if (rdy) seen = 1'b1;
      end
      check("abort_no_rdy", 32'(seen), 32'd0);

      // Loop-back: sign-magnitude value -> BCD digits -> converter -> same value.
      for (int i = 0; i < 8; i++) begin
         val    = (i == 0) ? 0 : int'($urandom_range(0, 32767));
         s      = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         exp_lb = (val == 0) ? 16'h0000 : {s, 15'(val)};
         convert("loopback", to_bcd(val), {3'($urandom_range(0, 7)), s}, exp_lb, 1'b0, 1'b0, 19);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_to_bin.md
BCD_TO_BIN -- requirements
Module: bcd_to_bin

Interface
REQ-001 Parameter N_DIGITS, default 5, number of BCD input digits (fixed; other values are not supported).
REQ-002 Parameter MAG_W, default 15, width of the binary magnitude field.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  conversion request, sampled only in IDLE.
REQ-007 bcd_d_in_1..bcd_d_in_5  input  4 each  BCD digits; _1 is ones, _5 is ten-thousands.
REQ-008 plus_minus  input  4  sign; bit0=1 means negative; bits 3:1 ignored.
REQ-009 bin_d_out  output  16  sign-magnitude result: [15] sign, [14:0] magnitude.
REQ-010 rdy  output  1  one-cycle result-valid pulse.
REQ-011 busy  output  1  high from the accept edge until rdy deasserts.
REQ-012 err_digit  output  1  some input digit > 9; valid with rdy.
REQ-013 ovf  output  1  magnitude > 32767; valid with rdy.

Function
REQ-014 FSM states SHALL be IDLE, CHECK, CONVERT, DONE.
REQ-015 IDLE: when en=1, capture all digits and plus_minus[0], set busy=1, go to CHECK (accept edge E0).
REQ-016 en SHALL be ignored in every state except IDLE; captured operands SHALL NOT change mid-conversion.
REQ-017 CHECK: any digit > 9 -> set err_digit flag and go to DONE; else clear 5-bit shift counter and go to CONVERT.
REQ-018 CONVERT: per cycle, shift {bcd[19:0], acc[16:0]} right 1 bit, then subtract 3 from each 4-bit digit >= 8 (all digits in parallel, same cycle).
REQ-019 CONVERT SHALL run exactly 17 cycles (counter 0..16); on counter=16 go to DONE.
REQ-020 Internal accumulator SHALL be 17 bits (max 99999 < 2^17).
REQ-021 DONE: register outputs, pulse rdy for exactly one cycle, then IDLE with busy=0.
REQ-022 Valid path: rdy high in the cycle after edge E0+19; invalid-digit path: after edge E0+2.
REQ-023 acc > 32767 -> ovf=1, bin_d_out=16'h0000.
REQ-024 err_digit=1 -> bin_d_out=16'h0000, ovf=0.
REQ-025 Magnitude 0 SHALL yield sign bit 0 regardless of plus_minus (no negative zero).
REQ-026 Otherwise bin_d_out={sign, acc[14:0]}, err_digit=0, ovf=0.
REQ-027 bin_d_out, err_digit, ovf SHALL hold their values until the next DONE.
REQ-028 A new en is accepted in the first IDLE cycle after rdy (back-to-back allowed).

Reset
REQ-029 rst SHALL force state=IDLE, busy=0, rdy=0, bin_d_out=0, err_digit=0, ovf=0, counter=0.
REQ-030 rst takes priority over en and all state transitions.
REQ-031 rst mid-conversion SHALL abort with no rdy pulse for that request.

Structure
REQ-032 Package bcd_pkg SHALL hold the FSM state enum, N_DIGITS, MAG_W, and the 17-bit accumulator width constant.
REQ-033 Sub-module bcd_digit_corr (4-bit in/out; >=8 -> minus 3) SHALL be instantiated 5 times inside CONVERT.
REQ-034 Output format SHALL match the BCDConvert input (bit15 sign, 14:0 magnitude) for loop-back testing.

Verification
REQ-035 Digits 1,2,3,4,5 (12345), sign 0 -> bin_d_out=16'h3039, rdy at E0+19, busy low after.
REQ-036 32767 -> 16'h7FFF, ovf=0; 32768 -> 16'h0000, ovf=1; 99999 -> ovf=1.
REQ-037 00001 with plus_minus=4'h1 -> 16'h8001; 00000 with plus_minus=4'h1 -> 16'h0000.
REQ-038 Digit _3=4'hA -> err_digit=1, bin_d_out=0, rdy at E0+2.
REQ-039 en held high with changing digits during conversion -> result reflects E0 capture only; rst at E0+10 -> no rdy, all outputs 0.
REQ-040 Loop-back: random sign-magnitude values into BCDConvert, its outputs into bcd_to_bin -> bin_d_out equals original (except -0 -> 0).
